// File: rtl/matmul_stream_unit_pkg.sv
// rtl/matmul_stream_unit_pkg.sv - shared state encoding and output conversion helpers for matmul_stream_unit
package matmul_stream_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // Row index width; a single-row array still needs a 1-bit index.
    function automatic int row_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Range check for the output conversion: bit 1 = above max, bit 0 = below min.
    // When sat_en is clear the caller always truncates.
    function automatic logic [1:0] sat_code(input logic signed [63:0] v,
                                            input int dw,
                                            input bit sat_en);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        sat_code = 2'b00;
        if (sat_en && (v > hi)) sat_code = 2'b10;
        if (sat_en && (v < lo)) sat_code = 2'b01;
    endfunction

endpackage

// File: rtl/matmul_stream_pe.sv
// rtl/matmul_stream_pe.sv - one signed MAC cell with clear and enable; accumulator wraps
module matmul_stream_pe #(
    parameter int DWIDTH = 16,
    parameter int ACCW   = 40
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_i,
    input  logic                     en_i,
    input  logic signed [DWIDTH-1:0] a_i,
    input  logic signed [DWIDTH-1:0] b_i,
    output logic signed [ACCW-1:0]   acc_o
);

    logic signed [2*DWIDTH-1:0] prod;
    logic signed [ACCW-1:0]     acc_q;
    logic signed [ACCW-1:0]     acc_d;

    always_comb begin
        prod  = a_i * b_i;
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + ACCW'(prod);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/matmul_stream_unit.sv
// rtl/matmul_stream_unit.sv - NxN output-stationary streamed matmul; MATMUL_SATURATE_EN selects saturating output
module matmul_stream_unit
    import matmul_stream_unit_pkg::*;
#(
    parameter int N          = 8,
    parameter int DWIDTH     = 16,
    parameter int ACCW       = 40,
    parameter int KW         = 8,
    parameter int REGIDWIDTH = 8,
    localparam int ROWW      = row_width(N)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [KW-1:0]          k_len,
    input  logic                   acc_mode,
    input  logic [REGIDWIDTH-1:0]  in_dst,
    input  logic [N-1:0]           mask_rows,
    input  logic [N-1:0]           mask_cols,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*DWIDTH-1:0]    a_data,
    input  logic [N*DWIDTH-1:0]    b_data,
    output logic                   busy,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*DWIDTH-1:0]    c_data,
    output logic [ROWW-1:0]        out_row,
    output logic [REGIDWIDTH-1:0]  out_dst,
    output logic                   out_dst_we,
    output logic                   done
);

`ifdef MATMUL_SATURATE_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [KW-1:0]         k_len_q, k_len_d;
    logic [KW-1:0]         beat_q, beat_d;
    logic [ROWW-1:0]       row_q, row_d;
    logic [REGIDWIDTH-1:0] dst_q, dst_d;
    logic [N-1:0]          mrows_q, mrows_d;
    logic [N-1:0]          mcols_q, mcols_d;
    logic                  done_q, done_d;

    logic                  pe_clr;
    logic                  pe_en;
    logic [N*N*ACCW-1:0]   acc_flat;
    logic signed [ACCW-1:0] sel_acc;
    logic [1:0]            sel_sat;

    assign pe_clr = (state_q == ST_IDLE) && start && !acc_mode;
    assign pe_en  = (state_q == ST_LOAD) && in_valid;

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            matmul_stream_pe #(
                .DWIDTH (DWIDTH),
                .ACCW   (ACCW)
            ) u_pe (
                .clk   (clk),
                .reset (reset),
                .clr_i (pe_clr),
                .en_i  (pe_en),
                .a_i   (a_data[gi*DWIDTH +: DWIDTH]),
                .b_i   (b_data[gj*DWIDTH +: DWIDTH]),
                .acc_o (acc_flat[(gi*N+gj)*ACCW +: ACCW])
            );
        end
    end

    always_comb begin
        state_d = state_q;
        k_len_d = k_len_q;
        beat_d  = beat_q;
        row_d   = row_q;
        dst_d   = dst_q;
        mrows_d = mrows_q;
        mcols_d = mcols_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    k_len_d = k_len;
                    dst_d   = in_dst;
                    mrows_d = mask_rows;
                    mcols_d = mask_cols;
                    beat_d  = '0;
                    row_d   = '0;
                    state_d = (k_len != '0) ? ST_LOAD : ST_DRAIN;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    beat_d = beat_q + KW'(1);
                    if (beat_q == k_len_q - KW'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (row_q == ROWW'(N - 1)) begin
                        row_d   = '0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + ROWW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            k_len_q <= '0;
            beat_q  <= '0;
            row_q   <= '0;
            dst_q   <= '0;
            mrows_q <= '0;
            mcols_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_len_q <= k_len_d;
            beat_q  <= beat_d;
            row_q   <= row_d;
            dst_q   <= dst_d;
            mrows_q <= mrows_d;
            mcols_q <= mcols_d;
            done_q  <= done_d;
        end
    end

    assign in_ready   = (state_q == ST_LOAD);
    assign busy       = (state_q != ST_IDLE);
    assign out_valid  = (state_q == ST_DRAIN);
    assign out_row    = row_q;
    assign out_dst    = dst_q;
    assign out_dst_we = (state_q == ST_DRAIN) && mrows_q[row_q];
    assign done       = done_q;

    // Masked rows/lanes read as zero; the accumulators behind them are untouched.
    always_comb begin
        c_data  = '0;
        sel_acc = '0;
        sel_sat = 2'b00;
        if ((state_q == ST_DRAIN) && mrows_q[row_q]) begin
            for (int j = 0; j < N; j++) begin
                if (mcols_q[j]) begin
                    sel_acc = acc_flat[(int'(row_q)*N + j)*ACCW +: ACCW];
                    sel_sat = sat_code(64'(sel_acc), DWIDTH, SAT_EN);
                    if (sel_sat[1]) begin
                        c_data[j*DWIDTH +: DWIDTH] = {1'b0, {(DWIDTH-1){1'b1}}};
                    end else if (sel_sat[0]) begin
                        c_data[j*DWIDTH +: DWIDTH] = {1'b1, {(DWIDTH-1){1'b0}}};
                    end else begin
                        c_data[j*DWIDTH +: DWIDTH] = sel_acc[DWIDTH-1:0];
                    end
                end
            end
        end
    end

endmodule
